// File: rtl/mccoy_pkg.sv
// Shared types and constants for the McCoy fetch sequencer.
//   state_e : top-level sequencer state (idle, core reset phase, running)
//   phase_e : the four clk-long phases of one core cycle
//   IO_*    : bit positions of the fields packed onto core_io_in
package mccoy_pkg;

  localparam int unsigned PROG_DEPTH = 16;
  localparam int unsigned PC_W       = 4;
  localparam int unsigned INSTR_W    = 6;
  localparam int unsigned RST_CYCLES = 2;
  localparam int unsigned RST_CNT_W  = $clog2(RST_CYCLES + 1);

  localparam int unsigned IO_CLK_BIT   = 0;
  localparam int unsigned IO_RST_BIT   = 1;
  localparam int unsigned IO_INSTR_LSB = 2;

  typedef enum logic [1:0] {StIdle, StRst, StRun} state_e;

  // Core clock is low in PhL0/PhL1 and high in PhH0/PhH1.
  typedef enum logic [1:0] {PhL0, PhL1, PhH0, PhH1} phase_e;

endpackage

// File: rtl/mccoy_prog_mem.sv
// 16 x 6-bit program store: synchronous write, asynchronous read.
//   clk   : system clock
//   we    : write enable (already qualified by the caller)
//   waddr : write address
//   wdata : instruction word to store
//   raddr : read address
//   rdata : instruction at raddr (combinational)
module mccoy_prog_mem
  import mccoy_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [PC_W-1:0]    waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [PC_W-1:0]    raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [PROG_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mccoy_fetch_ctrl.sv
// Instruction-fetch sequencer for the McCoy core. Generates the core clock and
// reset, samples the core's multiplexed output bus and feeds instructions back.
//   clk, reset   : system clock, synchronous active-high reset
//   prog_we/addr/data : program store write port (IDLE only)
//   start, abort : run control; run_cycles is the core-cycle budget (0 = unlimited)
//   core_io_in   : {instr[5:0], core_reset, core_clk} driven to the core
//   core_io_out  : core bus, PC while core_clk=1, x8 while core_clk=0
//   busy, done, fault : run status; pc_q, x8_q : last sampled core values
module mccoy_fetch_ctrl
  import mccoy_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  input  logic               abort,
  input  logic [7:0]         run_cycles,
  output logic [7:0]         core_io_in,
  input  logic [7:0]         core_io_out,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [7:0]         pc_q,
  output logic [7:0]         x8_q
);

  state_e               state_q;
  phase_e               phase_q;
  logic [RST_CNT_W-1:0] rst_cnt_q;
  logic [7:0]           budget_q;
  logic                 unlimited_q;
  logic [INSTR_W-1:0]   instr_q;
  logic                 core_rst_q;
  logic                 core_clk_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 fault_q;
  logic [7:0]           pc_sample_q;
  logic [7:0]           x8_sample_q;

  logic [INSTR_W-1:0]   mem_rdata;
  logic                 pc_fault;
  logic                 budget_end;
  logic                 core_clk_next;

  mccoy_prog_mem u_prog_mem (
    .clk   (clk),
    .we    (prog_we && (state_q == StIdle)),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_sample_q[PC_W-1:0]),
    .rdata (mem_rdata)
  );

  // Only meaningful at PhH1 of a run, where core_io_out carries the PC.
  assign pc_fault      = (core_io_out[7:PC_W] != '0);
  assign budget_end    = !unlimited_q && (budget_q == 8'd1);
  // Core clock is high in the phase after PhL1 and after PhH0.
  assign core_clk_next = (phase_q == PhL1) || (phase_q == PhH0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      phase_q     <= PhL0;
      rst_cnt_q   <= '0;
      budget_q    <= '0;
      unlimited_q <= 1'b0;
      instr_q     <= '0;
      core_rst_q  <= 1'b0;
      core_clk_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      pc_sample_q <= '0;
      x8_sample_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q    <= StIdle;
        phase_q    <= PhL0;
        instr_q    <= '0;
        core_rst_q <= 1'b0;
        core_clk_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              state_q     <= StRst;
              phase_q     <= PhL0;
              rst_cnt_q   <= '0;
              budget_q    <= run_cycles;
              unlimited_q <= (run_cycles == 8'd0);
              fault_q     <= 1'b0;
              pc_sample_q <= '0;
              busy_q      <= 1'b1;
              core_rst_q  <= 1'b1;
              core_clk_q  <= 1'b0;
              instr_q     <= '0;
            end
          end
          StRst: begin
            phase_q    <= phase_e'(phase_q + 2'd1);
            core_clk_q <= core_clk_next;
            if (phase_q == PhH1) begin
              rst_cnt_q <= rst_cnt_q + RST_CNT_W'(1);
              if (rst_cnt_q == RST_CNT_W'(RST_CYCLES - 1)) begin
                state_q    <= StRun;
                core_rst_q <= 1'b0;
              end
            end
          end
          StRun: begin
            phase_q    <= phase_e'(phase_q + 2'd1);
            core_clk_q <= core_clk_next;
            unique case (phase_q)
              PhL0: instr_q     <= mem_rdata;
              PhL1: x8_sample_q <= core_io_out;
              PhH0: ;
              PhH1: begin
                pc_sample_q <= core_io_out;
                if (!unlimited_q) begin
                  budget_q <= budget_q - 8'd1;
                end
                if (pc_fault) begin
                  fault_q <= 1'b1;
                end
                if (pc_fault || budget_end) begin
                  state_q    <= StIdle;
                  phase_q    <= PhL0;
                  done_q     <= 1'b1;
                  busy_q     <= 1'b0;
                  core_clk_q <= 1'b0;
                  instr_q    <= '0;
                end
              end
            endcase
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign core_io_in = {instr_q, core_rst_q, core_clk_q};
  assign busy       = busy_q;
  assign done       = done_q;
  assign fault      = fault_q;
  assign pc_q       = pc_sample_q;
  assign x8_q       = x8_sample_q;

endmodule

// File: tb/tb_mccoy_fetch_ctrl.sv
// Self-checking bench for mccoy_fetch_ctrl: a scripted core model returns a
// chosen PC/x8 sequence, and expectations come from a run-level reference model.
module tb_mccoy_fetch_ctrl;

  logic       clk;
  logic       reset;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [5:0] prog_data;
  logic       start;
  logic       abort;
  logic [7:0] run_cycles;
  logic [7:0] core_io_in;
  logic [7:0] core_io_out;
  logic       busy;
  logic       done;
  logic       fault;
  logic [7:0] pc_q;
  logic [7:0] x8_q;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [5:0] mem_m [16];
  logic [7:0] pcs [512];
  logic [7:0] x8s [512];
  logic [8:0] idx = '0;
  logic       cclk;
  bit         poke_in_run = 0;

  mccoy_fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .start       (start),
    .abort       (abort),
    .run_cycles  (run_cycles),
    .core_io_in  (core_io_in),
    .core_io_out (core_io_out),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .pc_q        (pc_q),
    .x8_q        (x8_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: after k released rising edges it shows pcs[k-1] while high
  // and x8s[k] while low.
  assign cclk = core_io_in[0];
  always @(posedge cclk) idx <= core_io_in[1] ? 9'd0 : idx + 9'd1;
  assign core_io_out = cclk ? ((idx != 0) ? pcs[idx - 9'd1] : 8'h00) : x8s[idx];

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step_to(input int target, inout int c);
    repeat (target - c) @(negedge clk);
    c = target;
  endtask

  task automatic write_mem(input logic [3:0] a, input logic [5:0] d, input bit honoured);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
    if (honoured) mem_m[a] = d;
  endtask

  // Runs with budget n (>=1); the run ends after n cycles or at the first
  // cycle whose returned PC is out of range.
  task automatic do_run(input int n);
    int cycles;
    bit exp_fault;
    logic [7:0] prev;
    int d0;
    int c;
    cycles = n;
    exp_fault = 0;
    for (int k = 0; k < n; k++) begin
      if (pcs[k] >= 8'd16) begin
        cycles = k + 1;
        exp_fault = 1;
        break;
      end
    end
    d0 = done_cnt;
    @(negedge clk);
    run_cycles = n[7:0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    check("start_busy", busy, 1);
    check("start_fault", fault, 0);
    check("start_pc", pc_q, 0);
    check("rst_io", core_io_in, 8'h02);
    prev = 8'h00;
    for (int k = 1; k <= cycles; k++) begin
      step_to(8 + 4 * (k - 1) + 1, c);
      check("instr", core_io_in[7:2], mem_m[prev[3:0]]);
      check("cclk_low", core_io_in[1:0], 2'b00);
      if (poke_in_run && k == 1) begin
        // Both must be ignored while running.
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 6'h3F; start = 1'b1;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        c++;
      end else begin
        step_to(8 + 4 * (k - 1) + 2, c);
      end
      check("x8", x8_q, x8s[k - 1]);
      check("cclk_high", core_io_in[0], 1);
      step_to(8 + 4 * k, c);
      check("pc", pc_q, pcs[k - 1]);
      if (k < cycles) begin
        check("mid_done", done, 0);
        check("mid_busy", busy, 1);
      end else begin
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_fault", fault, exp_fault);
        check("end_io", core_io_in, 0);
      end
      prev = pcs[k - 1];
    end
    @(negedge clk);
    check("done_pulse", done, 0);
    check("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; abort = 1'b0; run_cycles = '0;
    for (int i = 0; i < 512; i++) begin
      pcs[i] = 8'h00;
      x8s[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_io", core_io_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_pc", pc_q, 0);
    check("rst_x8", x8_q, 0);

    for (int i = 0; i < 16; i++) write_mem(i[3:0], 6'($urandom), 1);

    // Incrementing core: fetches mem[0..3], ends with pc_q=4.
    write_mem(4'd0, 6'h01, 1);
    write_mem(4'd1, 6'h02, 1);
    write_mem(4'd2, 6'h03, 1);
    write_mem(4'd3, 6'h04, 1);
    for (int i = 0; i < 8; i++) pcs[i] = 8'(i + 1);
    do_run(4);

    // Constant core bus values.
    for (int i = 0; i < 8; i++) begin
      pcs[i] = 8'h02;
      x8s[i] = 8'hA5;
    end
    do_run(2);

    // Out-of-range PC on the first H1, then budget end coinciding with fault.
    pcs[0] = 8'h10;
    do_run(3);
    pcs[0] = 8'h01; pcs[1] = 8'hF3;
    do_run(2);

    // Writes and start pulses during a run are ignored; next run checks mem[0].
    pcs[0] = 8'h00; pcs[1] = 8'h00; pcs[2] = 8'h03;
    poke_in_run = 1;
    do_run(3);
    poke_in_run = 0;
    do_run(2);

    // Abort and start together in IDLE: stays idle.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", busy, 0);
    check("abort_start_io", core_io_in, 0);

    // Unlimited budget: still running after 300 core cycles, abort gives no done.
    for (int i = 0; i < 512; i++) pcs[i] = 8'($urandom_range(0, 15));
    d0 = done_cnt;
    @(negedge clk);
    run_cycles = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8 + 300 * 4) @(negedge clk);
    check("unl_busy", busy, 1);
    check("unl_fault", fault, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_io", core_io_in, 0);
    repeat (4) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);

    // Reset mid-run.
    @(negedge clk);
    run_cycles = 8'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_io", core_io_in, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pc", pc_q, 0);
    check("midrst_x8", x8_q, 0);
    check("midrst_done", done, 0);
    write_mem(4'd5, 6'h2A, 1);

    // Randomized runs.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 16; i++) write_mem(i[3:0], 6'($urandom), 1);
      for (int i = 0; i < 8; i++) begin
        pcs[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 255))
                                             : 8'($urandom_range(0, 15));
        x8s[i] = 8'($urandom);
      end
      do_run($urandom_range(1, 6));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mccoy_fetch_ctrl.md
# mccoy_fetch_ctrl

Instruction-fetch sequencer for the McCoy core. It holds a 16-entry, 6-bit program store and generates the core clock and reset. Each core cycle it samples the core's multiplexed output bus (PC while the core clock is high, x8 while low) and drives the instruction at the sampled PC onto the core's instr pins. It sits between a host load/run interface and the core's 8-bit `io_in`/`io_out` pads.

## Interface
- `PROG_DEPTH`, 16: program store entries; fixed, PC index width 4.
- `RST_CYCLES`, 2: core cycles with core reset held high at run start.
- `clk` in 1: system clock, the only clock.
- `reset` in 1: synchronous, active-high.
- `prog_we` in 1: program write strobe; honoured only in IDLE.
- `prog_addr` in 4: write address.
- `prog_data` in 6: instruction word.
- `start` in 1: single-cycle pulse; begins a run from IDLE.
- `abort` in 1: stops the run and returns to IDLE.
- `run_cycles` in 8: core-cycle budget, latched at `start`; 0 means unlimited.
- `core_io_in` out 8: {instr[5:0], core_reset, core_clk}, bit 0 = core clock.
- `core_io_out` in 8: core output bus, PC when core_clk=1, x8 when core_clk=0.
- `busy` out 1: run in progress, including the reset phase.
- `done` out 1: one-cycle pulse when a run ends by budget or fault.
- `fault` out 1: sticky; the sampled PC was ≥16. Cleared at `start`.
- `pc_q` out 8: last sampled core PC.
- `x8_q` out 8: last sampled core x8.

## Operation
- Reset values: `core_io_in`=0, `busy`=0, `done`=0, `fault`=0, `pc_q`=0, `x8_q`=0, state IDLE. The program store is not reset.
- States:
  - IDLE: core_clk=0, core_reset=0, instr=0.
  - RST: core_reset=1, instr=0, phases cycling for RST_CYCLES core cycles.
  - RUN: phases cycling.
- Transitions:
  - IDLE→RST on `start`. At that point, latch the budget, clear `fault`, set `pc_q`=0 and assert `busy`.
  - RST→RUN after the H1 phase of the last reset cycle.
  - RUN→IDLE on budget exhaustion or fault, with a `done` pulse.
  - Any state→IDLE on `abort`, with no `done` pulse.
- Each core cycle has 4 phases: L0, L1, H0, H1. core_clk=0 in L0/L1 and 1 in H0/H1.
  - End of L0: instr ← mem[pc_q[3:0]].
  - End of L1: `x8_q` ← `core_io_out`.
  - H0: core rising edge on entry.
  - End of H1: `pc_q` ← `core_io_out`. The budget counter decrements, unless it was latched as 0.
- Budget: the run ends at the H1 where the counter reaches 0. N core cycles are executed exactly.
- Fault: a `pc_q` sampled at H1 with any of bits [7:4] set sets `fault`, pulses `done`, and goes to IDLE without issuing a fetch.
- `prog_we` during RST or RUN is ignored. `start` during RST or RUN is ignored.
- Simultaneous `abort` and `start` in IDLE: `abort` wins and the block stays IDLE.
- Simultaneous budget end and fault at the same H1: `fault` set, one `done` pulse.
- `reset` at any time overrides everything, including a mid-run state.

## Timing
- One core cycle = 4 `clk` cycles. All outputs are registered.
- instr changes only at the end of L0, one `clk` before the core rising edge, and is held stable through H1.
- Latency from `start` to the first program fetch (end of L0 of the first RUN cycle) = 1 + 4·RST_CYCLES + 1 `clk` = 10 with defaults.
- `done` is asserted in the `clk` cycle after the terminating H1. `busy` falls in the same cycle.
- A program write takes effect the next `clk`.

## Structure
- Package `mccoy_pkg`: state enum {IDLE, RST, RUN}, phase enum {L0, L1, H0, H1}, PROG_DEPTH, RST_CYCLES, and the bit positions of the `core_io_in` fields.
- Sub-module `mccoy_prog_mem`: 16×6 array with synchronous write and asynchronous read.
- The FSM, phase counter, budget counter and sample registers live in the top module.

## Test plan
- Reset mid-RUN: `core_io_in`=0, `busy`=0, `pc_q`=0, state IDLE on the next `clk`.
- Load mem[0..3]=6'h01,6'h02,6'h03,6'h04, `run_cycles`=4, with a core model whose PC increments 0→1→2→3→4:
  - instr sequence 01,02,03,04 at the successive L0 ends.
  - `done` pulses 10+16 `clk` after `start`; `pc_q`=4.
- Core model holds x8=8'hA5 while low and PC=8'h02 while high:
  - `x8_q`=A5 and `pc_q`=02 after the first RUN cycle.
  - instr = mem[2] in the next cycle.
- Core model returns PC=8'h10 at the first H1: `fault`=1, one `done` pulse, IDLE; `fault` clears on the next `start`.
- `run_cycles`=0: still `busy` after 300 core cycles; `abort` → IDLE with no `done` pulse.
- `prog_we` to addr 0 with data 6'h3F during RUN is ignored: mem[0] is unchanged on the next run.
